// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge PWM generator: shared period counter, boundary-aligned duty updates and
// dead-time protected direction changes. Define SOFT_START_EN to ramp duty after each dead time.
module motor_pwm_driver #(
    parameter int PERIOD      = 1000,
    parameter int DEAD_CYCLES = 50,
    parameter int RAMP_STEP   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic        in1_a,
    output logic        in2_a,
    output logic        pwm_a,
    output logic        in1_b,
    output logic        in2_b,
    output logic        pwm_b,
    output logic        busy_a,
    output logic        busy_b,
    output logic        period_start
);

`ifdef SOFT_START_EN
    localparam bit SOFT_START = 1'b1;
`else
    localparam bit SOFT_START = 1'b0;
`endif

    localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW  = $clog2(PERIOD + 1);
    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_CYCLES - 1);
    localparam logic [DW-1:0]  DUTY_FULL = DW'(PERIOD);

    typedef enum logic {ST_RUN, ST_DEAD} state_t;

    logic [1:0][1:0]  dir_raw;
    logic [1:0][11:0] factor_raw;
    logic [1:0]       in1_vec, in2_vec, pwm_vec, busy_vec;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             period_start_reg;

    // Index 0 is channel A, index 1 is channel B.
    assign dir_raw    = {directie_driverB, directie_driverA};
    assign factor_raw = {factor_dc_driverB, factor_dc_driverA};

    always_comb cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            period_start_reg <= (cnt_next == '0);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            state_t         state_reg, state_next;
            logic [1:0]     dir_reg, dir_q_reg, dir_q_next, dir_lat_reg, dir_lat_next;
            logic [11:0]    factor_reg;
            logic [DCW-1:0] dead_cnt_reg, dead_cnt_next;
            logic [DW-1:0]  duty_q_reg, duty_q_next, duty_eff;
            logic           enter_run, compare;
            logic           in1_reg, in1_next, in2_reg, in2_next;
            logic           pwm_reg, pwm_next, busy_reg, busy_next;

            assign duty_eff = (int'(factor_reg) >= PERIOD) ? DUTY_FULL : DW'(factor_reg);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dir_reg      <= 2'b11;
                    factor_reg   <= '0;
                    state_reg    <= ST_RUN;
                    dir_q_reg    <= 2'b11;
                    dir_lat_reg  <= 2'b11;
                    dead_cnt_reg <= '0;
                    duty_q_reg   <= '0;
                    in1_reg      <= 1'b0;
                    in2_reg      <= 1'b0;
                    pwm_reg      <= 1'b0;
                    busy_reg     <= 1'b0;
                end else begin
                    dir_reg      <= dir_raw[gi];
                    factor_reg   <= factor_raw[gi];
                    state_reg    <= state_next;
                    dir_q_reg    <= dir_q_next;
                    dir_lat_reg  <= dir_lat_next;
                    dead_cnt_reg <= dead_cnt_next;
                    duty_q_reg   <= duty_q_next;
                    in1_reg      <= in1_next;
                    in2_reg      <= in2_next;
                    pwm_reg      <= pwm_next;
                    busy_reg     <= busy_next;
                end
            end

            always_comb begin
                state_next    = state_reg;
                dir_q_next    = dir_q_reg;
                dir_lat_next  = dir_lat_reg;
                dead_cnt_next = dead_cnt_reg;
                duty_q_next   = duty_q_reg;
                enter_run     = 1'b0;
                in1_next      = 1'b0;
                in2_next      = 1'b0;
                pwm_next      = 1'b0;
                busy_next     = 1'b0;

                case (state_reg)
                    ST_RUN: begin
                        if (dir_reg != dir_q_reg) begin
                            state_next    = ST_DEAD;
                            dir_lat_next  = dir_reg;
                            dead_cnt_next = DEAD_LOAD;
                        end
                    end
                    default: begin
                        // A newer code restarts the full dead time.
                        if (dir_reg != dir_lat_reg) begin
                            dir_lat_next  = dir_reg;
                            dead_cnt_next = DEAD_LOAD;
                        end else if (dead_cnt_reg == '0) begin
                            state_next = ST_RUN;
                            dir_q_next = dir_lat_reg;
                            enter_run  = 1'b1;
                        end else begin
                            dead_cnt_next = dead_cnt_reg - DCW'(1);
                        end
                    end
                endcase

                // Duty changes only at the wrap so a running pulse is never cut or stretched.
                if (cnt_reg == CNT_LAST) begin
                    if (!SOFT_START) begin
                        duty_q_next = duty_eff;
                    end else if (duty_eff > duty_q_reg) begin
                        duty_q_next = (int'(duty_eff - duty_q_reg) > RAMP_STEP) ?
                                      duty_q_reg + DW'(RAMP_STEP) : duty_eff;
                    end else begin
                        duty_q_next = (int'(duty_q_reg - duty_eff) > RAMP_STEP) ?
                                      duty_q_reg - DW'(RAMP_STEP) : duty_eff;
                    end
                end
                if (SOFT_START && enter_run) begin
                    duty_q_next = '0;
                end

                // Outputs are derived from next-state values so they line up with cnt.
                compare = (DW'(cnt_next) < duty_q_next);
                if (state_next == ST_DEAD) begin
                    busy_next = 1'b1;
                end else begin
                    case (dir_q_next)
                        2'b01: begin
                            in1_next = 1'b1;
                            pwm_next = compare;
                        end
                        2'b10: begin
                            in2_next = 1'b1;
                            pwm_next = compare;
                        end
                        2'b00: begin
                            in1_next = 1'b1;
                            in2_next = 1'b1;
                            pwm_next = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            assign in1_vec[gi]  = in1_reg;
            assign in2_vec[gi]  = in2_reg;
            assign pwm_vec[gi]  = pwm_reg;
            assign busy_vec[gi] = busy_reg;
        end
    endgenerate

    assign in1_a        = in1_vec[0];
    assign in2_a        = in2_vec[0];
    assign pwm_a        = pwm_vec[0];
    assign busy_a       = busy_vec[0];
    assign in1_b        = in1_vec[1];
    assign in2_b        = in2_vec[1];
    assign pwm_b        = pwm_vec[1];
    assign busy_b       = busy_vec[1];
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: directed scenarios plus random stimulus, all checked
// every clock against a timestamp-based behavioural model (SOFT_START_EN adds the ramp scenario).
module tb_motor_pwm_driver;
    localparam int P    = 1000;
    localparam int D    = 50;
    localparam int STEP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dir_drv [2];
    logic [11:0] fac_drv [2];
    logic        in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, busy_a, busy_b, period_start;
    logic [8:0]  obs_vec, exp_vec;

    int errors = 0;
    int checks = 0;

    // Model state: edge count since reset, last registered direction change per channel.
    int         t;
    logic [1:0] m_prev_dir [2];
    int         m_prev_fac [2];
    int         m_last_chg [2];
    logic [1:0] m_pend     [2];
    bit         m_pending  [2];
    logic [1:0] m_applied  [2];
    int         m_duty     [2];

    always #5 clk = ~clk;

    motor_pwm_driver #(.PERIOD(P), .DEAD_CYCLES(D), .RAMP_STEP(STEP)) dut (
        .clk(clk), .rst(rst),
        .directie_driverA(dir_drv[0]), .directie_driverB(dir_drv[1]),
        .factor_dc_driverA(fac_drv[0]), .factor_dc_driverB(fac_drv[1]),
        .in1_a(in1_a), .in2_a(in2_a), .pwm_a(pwm_a),
        .in1_b(in1_b), .in2_b(in2_b), .pwm_b(pwm_b),
        .busy_a(busy_a), .busy_b(busy_b), .period_start(period_start)
    );

    assign obs_vec = {in1_a, in2_a, pwm_a, busy_a, in1_b, in2_b, pwm_b, busy_b, period_start};

    task automatic model_reset();
        t = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_prev_dir[ch] = 2'b11;
            m_prev_fac[ch] = 0;
            m_last_chg[ch] = -1000000;
            m_pend[ch]     = 2'b11;
            m_pending[ch]  = 1'b0;
            m_applied[ch]  = 2'b11;
            m_duty[ch]     = 0;
        end
        exp_vec = '0;
    endtask

    // Advance one clock and compute what the outputs must be after that edge.
    task automatic step();
        int         cnt, eff, nf;
        logic [1:0] nd;
        bit         busy, pw;
        logic [3:0] ch_out [2];
        @(posedge clk);
        t++;
        cnt = t % P;
        for (int ch = 0; ch < 2; ch++) begin
            nd  = dir_drv[ch];
            nf  = int'(fac_drv[ch]);
            eff = (m_prev_fac[ch] > P) ? P : m_prev_fac[ch];
            if (cnt == 0) begin
`ifdef SOFT_START_EN
                if (m_duty[ch] < eff) m_duty[ch] = (m_duty[ch] + STEP > eff) ? eff : m_duty[ch] + STEP;
                else                  m_duty[ch] = (m_duty[ch] - STEP < eff) ? eff : m_duty[ch] - STEP;
`else
                m_duty[ch] = eff;
`endif
            end
            busy = (t <= m_last_chg[ch] + D);
            if (!busy && m_pending[ch]) begin
                m_applied[ch] = m_pend[ch];
                m_pending[ch] = 1'b0;
`ifdef SOFT_START_EN
                m_duty[ch] = 0;
`endif
            end
            if (nd != m_prev_dir[ch]) begin
                m_last_chg[ch] = t;
                m_pend[ch]     = nd;
                m_pending[ch]  = 1'b1;
            end
            m_prev_dir[ch] = nd;
            m_prev_fac[ch] = nf;
            pw = (cnt < m_duty[ch]);
            if (busy)                          ch_out[ch] = 4'b0001;
            else if (m_applied[ch] == 2'b01)   ch_out[ch] = {2'b10, pw, 1'b0};
            else if (m_applied[ch] == 2'b10)   ch_out[ch] = {2'b01, pw, 1'b0};
            else if (m_applied[ch] == 2'b00)   ch_out[ch] = 4'b1110;
            else                               ch_out[ch] = 4'b0000;
        end
        exp_vec = {ch_out[0], ch_out[1], cnt == 0};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dir_drv[0] = 2'b01; dir_drv[1] = 2'b10;
        fac_drv[0] = 12'd500; fac_drv[1] = 12'd500;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_vec !== 9'd0) begin
            errors++;
            $display("FAIL reset_hold got=%b expected=%b", obs_vec, 9'd0);
        end
        dir_drv[0] = 2'b11; dir_drv[1] = 2'b11;
        fac_drv[0] = 12'd0; fac_drv[1] = 12'd0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL reset_idle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_forward();
        int busy_cnt = 0, hi = 0;
        int t0 = t;
        dir_drv[0] = 2'b01; dir_drv[1] = 2'b01;
        fac_drv[0] = 12'd999; fac_drv[1] = 12'd999;
        for (int i = 0; i < 2 * P - 5; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL forward_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
            if (busy_a) busy_cnt++;
            if (t >= P && t < 2 * P && pwm_a) hi++;
        end
        checks++;
        if (busy_cnt !== D) begin
            errors++;
            $display("FAIL forward_dead_len got=%0d expected=%0d (start t=%0d)", busy_cnt, D, t0);
        end
`ifndef SOFT_START_EN
        checks++;
        if (hi !== 999) begin
            errors++;
            $display("FAIL forward_high_count got=%0d expected=%0d", hi, 999);
        end
`endif
        checks++;
        if ({in1_a, in2_a} !== 2'b10) begin
            errors++;
            $display("FAIL forward_bridge got=%b expected=%b", {in1_a, in2_a}, 2'b10);
        end
    endtask

    task automatic test_reverse();
        int busy_cnt = 0;
        for (int i = 0; i < 137; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL reverse_pre t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
        end
        dir_drv[0] = 2'b10;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec || (in1_a && in2_a)) begin
                errors++;
                if (errors <= 25) $display("FAIL reverse_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
            if (busy_a) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== D) begin
            errors++;
            $display("FAIL reverse_dead_len got=%0d expected=%0d", busy_cnt, D);
        end
        checks++;
        if ({in1_a, in2_a} !== 2'b01) begin
            errors++;
            $display("FAIL reverse_bridge got=%b expected=%b", {in1_a, in2_a}, 2'b01);
        end
    endtask

    task automatic test_duty_change();
        int hi_cur = 0, hi_next = 0;
        for (int i = 0; i < P && (t % P) != P - 1; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL duty_align t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 2 * P; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL duty_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
            if (i < P && pwm_a) hi_cur++;
            if (i >= P && pwm_a) hi_next++;
            if (i == 300) fac_drv[0] = 12'd750;
        end
`ifndef SOFT_START_EN
        checks++;
        if (hi_cur !== 999) begin
            errors++;
            $display("FAIL duty_current_period got=%0d expected=%0d", hi_cur, 999);
        end
        checks++;
        if (hi_next !== 750) begin
            errors++;
            $display("FAIL duty_next_period got=%0d expected=%0d", hi_next, 750);
        end
`endif
    endtask

    task automatic test_limits();
        int brake_cnt = 0, full_cnt = 0, zero_cnt = 0;
        dir_drv[0] = 2'b00;
        fac_drv[1] = 12'd4095;
        for (int i = 0; i < 4 * P; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL limits_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
            if (i >= P && i < 2 * P) begin
                if (in1_a && in2_a && pwm_a) brake_cnt++;
                if (pwm_b) full_cnt++;
            end
            if (i == 2 * P - 1) fac_drv[1] = 12'd0;
            if (i >= 3 * P && pwm_b) zero_cnt++;
        end
        checks++;
        if (brake_cnt !== P) begin
            errors++;
            $display("FAIL brake_all_high got=%0d expected=%0d", brake_cnt, P);
        end
`ifndef SOFT_START_EN
        checks++;
        if (full_cnt !== P) begin
            errors++;
            $display("FAIL factor_4095_full got=%0d expected=%0d", full_cnt, P);
        end
`endif
        checks++;
        if (zero_cnt !== 0) begin
            errors++;
            $display("FAIL factor_0_never got=%0d expected=%0d", zero_cnt, 0);
        end
    endtask

    task automatic test_retrigger();
        int busy_cnt = 0;
        dir_drv[0] = 2'b01;
        for (int i = 0; i < 110; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL retrigger_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
            if (busy_a) busy_cnt++;
            if (i == 20) dir_drv[0] = 2'b10;
        end
        checks++;
        if (busy_cnt !== 21 + D) begin
            errors++;
            $display("FAIL retrigger_dead_len got=%0d expected=%0d", busy_cnt, 21 + D);
        end
        checks++;
        if ({in1_a, in2_a} !== 2'b01) begin
            errors++;
            $display("FAIL retrigger_final_dir got=%b expected=%b", {in1_a, in2_a}, 2'b01);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 299) == 0) dir_drv[ch] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 399) == 0) begin
                    if ($urandom_range(0, 3) == 0) fac_drv[ch] = 12'($urandom_range(P - 2, P + 2));
                    else                           fac_drv[ch] = 12'($urandom_range(0, 4095));
                end
            end
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL random_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_async_reset();
        dir_drv[0] = 2'b01; dir_drv[1] = 2'b01;
        fac_drv[0] = 12'd4095; fac_drv[1] = 12'd500;
        for (int i = 0; i < 2 * P + 100; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL async_pre t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
            if (i == 2 * P + 90) dir_drv[1] = 2'b10;
        end
        checks++;
        if ({pwm_a, busy_b} !== 2'b11) begin
            errors++;
            $display("FAIL async_pre_state got=%b expected=%b", {pwm_a, busy_b}, 2'b11);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec !== 9'd0) begin
            errors++;
            $display("FAIL async_reset_immediate got=%b expected=%b", obs_vec, 9'd0);
        end
        dir_drv[0] = 2'b01; dir_drv[1] = 2'b01;
        fac_drv[0] = 12'd300; fac_drv[1] = 12'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 1200; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL async_post t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
        end
    endtask

`ifdef SOFT_START_EN
    task automatic test_soft_start();
        int hi;
        for (int i = 0; i < P && (t % P) != P - 1; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                if (errors <= 25) $display("FAIL soft_align t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
            end
        end
        dir_drv[0] = 2'b10;
        fac_drv[0] = 12'd100;
        for (int k = 0; k <= 10; k++) begin
            hi = 0;
            for (int i = 0; i < P; i++) begin
                step();
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++;
                    if (errors <= 25) $display("FAIL soft_cycle t=%0d got=%b expected=%b", t, obs_vec, exp_vec);
                end
                if (pwm_a) hi++;
            end
            if (k > 0) begin
                checks++;
                if (hi !== STEP * k) begin
                    errors++;
                    $display("FAIL soft_ramp period=%0d got=%0d expected=%0d", k, hi, STEP * k);
                end
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_forward();
        test_reverse();
        test_duty_change();
        test_limits();
        test_retrigger();
        test_random();
        test_async_reset();
`ifdef SOFT_START_EN
        test_soft_start();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
